// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Multi-cycle load/store stage downstream of the ALU. It accepts
//            one lw/sw request, issues one command to data memory over a
//            valid/ready handshake, waits for the response and returns a
//            single-cycle completion pulse. Every access is bounded by a
//            timeout counter.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   TIMEOUT        cycles allowed in CMD or WAIT before abort (legal 2..255)
// Optional feature
//   MAU_ALIGN_CHECK_EN  when defined, a request whose req_addr[1:0] != 0 is
//                       aborted with rsp_err without touching memory
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   req_valid/req_ready    request handshake from the ALU stage
//   req_write/addr/wdata/rd  request fields (sw flag, address, data, dest reg)
//   mem_cmd_valid/ready    command handshake to data memory
//   mem_cmd_write/addr/wdata  captured request fields
//   mem_rsp_valid/rdata    memory response (read data or write ack)
//   rsp_valid              one-cycle completion pulse
//   rsp_write/err/rd/data  completion attributes
//   busy                   pipeline stall, high outside IDLE
// ============================================================================
module mem_access_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_cmd_valid,
    input  logic        mem_cmd_ready,
    output logic        mem_cmd_write,
    output logic [31:0] mem_cmd_addr,
    output logic [31:0] mem_cmd_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_rdata,
    output logic        rsp_valid,
    output logic        rsp_write,
    output logic        rsp_err,
    output logic [4:0]  rsp_rd,
    output logic [31:0] rsp_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Counter value at which a cycle without progress aborts the access.
    localparam logic [7:0] c_tmo_last = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        orphan_q, orphan_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  rd_q, rd_d;
    logic        err_q, err_d;
    logic [31:0] data_q, data_d;

    logic        req_ready_q;
    logic        busy_q;
    logic        cmd_valid_q;
    logic        rsp_valid_q;

    logic        w_misaligned;
    logic        w_tmo;

`ifdef MAU_ALIGN_CHECK_EN
    assign w_misaligned = (req_addr[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_tmo = (cnt_q == c_tmo_last);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        orphan_d = orphan_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        err_d    = err_q;
        data_d   = data_q;

        // A stale response from an earlier timed-out access is swallowed
        // wherever it shows up; the WAIT timeout below may override this.
        if (orphan_q && mem_rsp_valid) begin
            orphan_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rd_d    = req_rd;
                    err_d   = 1'b0;
                    data_d  = 32'd0;
                    cnt_d   = 8'd0;
                    if (w_misaligned) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_CMD;
                    end
                end
            end
            ST_CMD: begin
                if (mem_cmd_ready) begin
                    cnt_d   = 8'd0;
                    state_d = ST_WAIT;
                end else if (w_tmo) begin
                    // Withdrawing mem_cmd_valid is allowed on this bus, so
                    // no orphan tracking is needed for a CMD timeout.
                    cnt_d   = 8'd0;
                    err_d   = 1'b1;
                    data_d  = 32'd0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_WAIT: begin
                if (mem_rsp_valid && !orphan_q) begin
                    cnt_d   = 8'd0;
                    err_d   = 1'b0;
                    data_d  = write_q ? 32'd0 : mem_rsp_rdata;
                    state_d = ST_RESP;
                end else if (w_tmo) begin
                    // The memory still owes us a response; mark it so it is
                    // discarded. Setting wins over a same-cycle clear.
                    cnt_d    = 8'd0;
                    err_d    = 1'b1;
                    data_d   = 32'd0;
                    orphan_d = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                cnt_d   = 8'd0;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = 8'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, captured fields and the handshake outputs are all registered
    // together; the outputs are decoded from the next state so they line up
    // with state_q without any input-to-output combinational path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            orphan_q    <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rd_q        <= 5'd0;
            err_q       <= 1'b0;
            data_q      <= 32'd0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            orphan_q    <= orphan_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            err_q       <= err_d;
            data_q      <= data_d;
            req_ready_q <= (state_d == ST_IDLE);
            busy_q      <= (state_d != ST_IDLE);
            cmd_valid_q <= (state_d == ST_CMD);
            rsp_valid_q <= (state_d == ST_RESP);
        end
    end

    assign req_ready     = req_ready_q;
    assign busy          = busy_q;
    assign mem_cmd_valid = cmd_valid_q;
    assign mem_cmd_write = write_q;
    assign mem_cmd_addr  = addr_q;
    assign mem_cmd_wdata = wdata_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_write     = write_q;
    assign rsp_err       = err_q;
    assign rsp_rd        = rd_q;
    assign rsp_data      = data_q;

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

Multi-cycle load/store stage sitting directly downstream of the ALU in the MIPS datapath. For `lw`/`sw` it does four things:
- takes the ALU result as the effective address, plus the store data and destination register;
- issues a single command to the data memory over a valid/ready handshake;
- waits for the memory response;
- returns one response pulse to the writeback/control logic.

It holds the pipeline busy for the whole access and bounds every access with a timeout.

## Interface
Parameters:
- TIMEOUT, 15, cycles allowed in CMD or WAIT before aborting; legal range 2..255.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  load/store request from the ALU stage.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid & req_ready.
- req_write  in  1  1 = sw, 0 = lw.
- req_addr  in  32  effective address (ALU result).
- req_wdata  in  32  store data (rt).
- req_rd  in  5  destination register for lw.
- mem_cmd_valid  out  1  command to data memory.
- mem_cmd_ready  in  1  memory accepts command.
- mem_cmd_write  out  1  captured req_write.
- mem_cmd_addr  out  32  captured req_addr.
- mem_cmd_wdata  out  32  captured req_wdata.
- mem_rsp_valid  in  1  memory response (read data or write ack), one cycle.
- mem_rsp_rdata  in  32  read data, valid with mem_rsp_valid.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_write  out  1  completed access was a store.
- rsp_err  out  1  access aborted (timeout or misalignment).
- rsp_rd  out  5  captured req_rd.
- rsp_data  out  32  load data; 0 for stores and errors.
- busy  out  1  high in every state except IDLE; drives pipeline stall.

## Operation
States: IDLE, CMD, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On accept, write, addr, wdata and rd are captured.
  - Next state is CMD, or RESP with err = 1 when the alignment check (see Configuration) fails.
- CMD:
  - mem_cmd_valid = 1 and the captured fields are driven.
  - On mem_cmd_ready, go to WAIT.
- WAIT:
  - On mem_rsp_valid (and orphan flag clear), latch mem_rsp_rdata (loads only), set err = 0 and go to RESP.
- RESP:
  - rsp_valid = 1 for exactly one cycle, then go to IDLE.
  - The writeback consumer writes the register file only when rsp_valid & !rsp_write & !rsp_err.
- Timeout:
  - An 8-bit counter clears on every state entry.
  - It increments each cycle in CMD/WAIT without the advancing event.
  - If it equals TIMEOUT-1 in a cycle with no event, the next state is RESP with err = 1 and rsp_data = 0.
  - A CMD timeout withdraws mem_cmd_valid; this is permitted on this bus.
- Orphan flag:
  - Set when WAIT times out.
  - While set, the first mem_rsp_valid is discarded and clears the flag.
  - That response is never delivered, in any state.
  - A response in the same cycle as the flag is set does not clear it.
- mem_rsp_valid is ignored in IDLE, CMD and RESP, except that it clears the orphan flag.
- mem_cmd_ready outside CMD is ignored.

## Timing
- Reset:
  - State is IDLE, with counter, orphan flag and all captured registers at 0.
  - Outputs: req_ready = 1, busy = 0; mem_cmd_valid, rsp_valid, rsp_err and rsp_write are 0; all data/address outputs are 0.
- Reset asserted mid-access:
  - The access is dropped immediately and asynchronously; no rsp_valid is produced.
  - The orphan flag clears.
- Minimum latency:
  - Request accepted at cycle 0; CMD at cycle 1 with mem_cmd_ready = 1.
  - WAIT at cycle 2 with mem_rsp_valid = 1.
  - rsp_valid at cycle 3; req_ready again at cycle 4.
- A response in the same cycle the command is accepted (still in CMD) is ignored.
- Back-to-back requests: at most one access in flight, with no overlap.
- busy = !req_ready, registered from state; there are no combinational paths from inputs to outputs.
- A misalignment error produces rsp_valid at cycle 1 (IDLE → RESP).

## Configuration
- Macro: MAU_ALIGN_CHECK_EN.
- Defined:
  - An accepted request with req_addr[1:0] != 2'b00 issues no memory command.
  - The unit goes directly to RESP with rsp_err = 1 and rsp_data = 0.
- Undefined:
  - No check is made; the address is passed to mem_cmd_addr unchanged, low bits included.
  - rsp_err is asserted only by timeouts.

## Test plan
- **Load, zero wait:** lw, addr 0x0000_0010, rd = 8, memory ready and responding immediately with 0xDEAD_BEEF → rsp_valid at cycle 3 with rsp_data = 0xDEAD_BEEF, rsp_rd = 8, rsp_err = 0, rsp_write = 0.
- **Store with backpressure:** sw, addr 0x0000_0020, wdata 0x1234_5678, mem_cmd_ready low for 3 cycles, ack 2 cycles after accept → mem_cmd_valid held 4 cycles with stable fields; rsp_valid with rsp_write = 1, rsp_data = 0.
- **WAIT timeout, TIMEOUT = 4:** no response → rsp_err = 1 exactly 4 cycles after entering WAIT. Then issue a late response followed by a new lw → the late response is discarded and the new lw returns its own data.
- **Reset mid-access:** assert rst while in WAIT → req_ready = 1, busy = 0 and mem_cmd_valid = 0 immediately; no rsp_valid; the next lw completes normally.
- **Alignment, MAU_ALIGN_CHECK_EN defined:** lw at 0x0000_0013 → no mem_cmd_valid; rsp_valid at cycle 1 with rsp_err = 1. With the macro undefined → mem_cmd_addr = 0x0000_0013.
